lock_ctrl_fsm: RTL

Password-lock sequencing controller for the switch/button lock system. It consumes single-cycle, already-conditioned entry events: digit, OK, backspace and admin. It assembles a 4-digit BCD code, compares it against a stored key, and tracks failed attempts. It also times the unlock, error and alarm intervals, and lets an unlocked user reprogram the key. Display and LED drivers read its state and code outputs.

---
 rtl/lock_ctrl_fsm.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lock_ctrl_fsm.sv
// lock_ctrl_fsm -- password-lock sequencing controller.
//
// Collects a 4-digit BCD code from conditioned single-cycle events and
// compares it against an internal key. It counts failed attempts, times the
// unlock/error/alarm intervals, and lets an unlocked user reprogram the key.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_digit_vld, i_digit  digit event and its value (0..9 accepted)
//   i_ok_p, i_bksp_p      confirm / backspace pulses
//   i_admin_p             admin pulse (enter/abort key programming)
//   o_state               state encoding (WAIT=0 INPUT=1 UNLOCK=2 ERROR=3
//                         ALARM=4 SETKEY=5)
//   o_code, o_code_cnt    digits entered so far (newest in [3:0]) and count
//   o_err_cnt             consecutive failed attempts (saturates at 3)
//   o_unlock, o_alarm     state decodes
//
// Build option: define LOCK_ALARM_LATCH_EN to make ALARM hold until reset.
module lock_ctrl_fsm #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned UNLOCK_MS   = 5000,
  parameter int unsigned ERR_MS      = 1000,
  parameter int unsigned ALARM_MS    = 10000,
  parameter int unsigned MAX_ERR     = 3,
  parameter logic [15:0] DEFAULT_KEY = 16'h1234
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_digit_vld,
  input  logic [3:0]  i_digit,
  input  logic        i_ok_p,
  input  logic        i_bksp_p,
  input  logic        i_admin_p,
  output logic [2:0]  o_state,
  output logic [15:0] o_code,
  output logic [2:0]  o_code_cnt,
  output logic [1:0]  o_err_cnt,
  output logic        o_unlock,
  output logic        o_alarm
);

  localparam int unsigned MAX_A  = (UNLOCK_MS > ERR_MS) ? UNLOCK_MS : ERR_MS;
  localparam int unsigned MAX_MS = (MAX_A > ALARM_MS) ? MAX_A : ALARM_MS;
  localparam int unsigned PS_W   = $clog2(TICK_DIV);
  localparam int unsigned MS_W   = (MAX_MS < 2) ? 1 : $clog2(MAX_MS);

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] UNL_LAST = MS_W'(UNLOCK_MS - 1);
  localparam logic [MS_W-1:0] ERR_LAST = MS_W'(ERR_MS - 1);
`ifndef LOCK_ALARM_LATCH_EN
  localparam logic [MS_W-1:0] ALM_LAST = MS_W'(ALARM_MS - 1);
`endif

  typedef enum logic [2:0] {
    S_WAIT   = 3'b000,
    S_INPUT  = 3'b001,
    S_UNLOCK = 3'b010,
    S_ERROR  = 3'b011,
    S_ALARM  = 3'b100,
    S_SETKEY = 3'b101
  } state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_code, w_code;
  logic [2:0]      r_cnt, w_cnt;
  logic [1:0]      r_err, w_err;
  logic [15:0]     r_key, w_key;
  logic [PS_W-1:0] r_presc;
  logic [MS_W-1:0] r_ms;

  logic            w_ev_ok, w_ev_bksp, w_ev_dig, w_dig_acc;
  logic            w_tick, w_timeout;
  logic [MS_W-1:0] w_ms_last;
  logic [1:0]      w_err_inc;

  // Only the highest-priority event of a cycle survives.
  assign w_ev_ok   = i_ok_p & ~i_admin_p;
  assign w_ev_bksp = i_bksp_p & ~i_ok_p & ~i_admin_p;
  assign w_ev_dig  = i_digit_vld & ~i_bksp_p & ~i_ok_p & ~i_admin_p;
  assign w_dig_acc = w_ev_dig && (i_digit <= 4'd9) && (r_cnt < 3'd4);
  assign w_err_inc = (r_err == 2'd3) ? 2'd3 : r_err + 2'd1;

  always_comb begin
    w_ms_last = ERR_LAST;
    if (r_state == S_UNLOCK) w_ms_last = UNL_LAST;
`ifndef LOCK_ALARM_LATCH_EN
    if (r_state == S_ALARM)  w_ms_last = ALM_LAST;
`endif
  end

  assign w_tick    = (r_presc == PS_LAST);
  assign w_timeout = w_tick && (r_ms == w_ms_last);

  // State register, data registers and interval timer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_WAIT;
      r_code  <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_key   <= DEFAULT_KEY;
      r_presc <= '0;
      r_ms    <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      r_cnt   <= w_cnt;
      r_err   <= w_err;
      r_key   <= w_key;
      // Any state change restarts the timer, which covers every timed entry.
      if (w_next != r_state) begin
        r_presc <= '0;
        r_ms    <= '0;
      end else if (r_state == S_UNLOCK || r_state == S_ERROR || r_state == S_ALARM) begin
        if (w_tick) begin
          r_presc <= '0;
          r_ms    <= r_ms + 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  // Next-state and next-data logic.
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    w_cnt  = r_cnt;
    w_err  = r_err;
    w_key  = r_key;
    case (r_state)
      S_WAIT: begin
        if (w_dig_acc) begin
          w_code = {r_code[11:0], i_digit};
          w_cnt  = r_cnt + 3'd1;
          w_next = S_INPUT;
        end
      end
      S_INPUT: begin
        if (w_ev_ok) begin
          if (r_cnt == 3'd4) begin
            if (r_code == r_key) begin
              w_next = S_UNLOCK;
              w_err  = '0;
            end else begin
              w_err  = w_err_inc;
              w_next = ({30'd0, w_err_inc} >= MAX_ERR) ? S_ALARM : S_ERROR;
            end
          end
        end else if (w_ev_bksp) begin
          if (r_cnt != 3'd0) begin
            w_code = {4'h0, r_code[15:4]};
            w_cnt  = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_next = S_WAIT;
          end
        end else if (w_dig_acc) begin
          w_code = {r_code[11:0], i_digit};
          w_cnt  = r_cnt + 3'd1;
        end
      end
      S_UNLOCK: begin
        // Relock and admin take precedence over a coincident timeout.
        if (i_admin_p)      w_next = S_SETKEY;
        else if (w_ev_ok)   w_next = S_WAIT;
        else if (w_timeout) w_next = S_WAIT;
      end
      S_SETKEY: begin
        if (i_admin_p) begin
          w_next = S_WAIT;
        end else if (w_ev_ok) begin
          if (r_cnt == 3'd4) begin
            w_key  = r_code;
            w_next = S_WAIT;
          end
        end else if (w_ev_bksp) begin
          if (r_cnt != 3'd0) begin
            w_code = {4'h0, r_code[15:4]};
            w_cnt  = r_cnt - 3'd1;
          end
        end else if (w_dig_acc) begin
          w_code = {r_code[11:0], i_digit};
          w_cnt  = r_cnt + 3'd1;
        end
      end
      S_ERROR: begin
        if (w_timeout) w_next = S_WAIT;
      end
      S_ALARM: begin
`ifndef LOCK_ALARM_LATCH_EN
        if (w_timeout) begin
          w_next = S_WAIT;
          w_err  = '0;
        end
`endif
      end
      default: w_next = S_WAIT;
    endcase
    // Entering any state other than INPUT starts with an empty code.
    if (w_next != r_state && w_next != S_INPUT) begin
      w_code = '0;
      w_cnt  = '0;
    end
  end

  // Output decode.
  always_comb begin
    o_state    = r_state;
    o_code     = r_code;
    o_code_cnt = r_cnt;
    o_err_cnt  = r_err;
    o_unlock   = (r_state == S_UNLOCK);
    o_alarm    = (r_state == S_ALARM);
  end

endmodule
